// File: rtl/array_gather_if.sv
// Handshake bundle for array_gather: four multi-lane source buses in, one merged bus out.
// The slave modport is the collector's view; master is the surrounding logic's view.
interface array_gather_if #(
  parameter int ARRAY_SIZE = 9,
  parameter int DATA_SIZE  = 16
);
  localparam int W = ARRAY_SIZE * DATA_SIZE;

  logic [W-1:0] i_d_in_1;
  logic [W-1:0] i_d_in_2;
  logic [W-1:0] i_d_in_3;
  logic [W-1:0] i_d_in_4;
  logic [3:0]   i_in_valid;
  logic [3:0]   o_in_ready;
  logic [W-1:0] o_d_out;
  logic [1:0]   o_out_sel;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [15:0]  o_beat_count;

  modport slave (
    input  i_d_in_1, i_d_in_2, i_d_in_3, i_d_in_4, i_in_valid, i_out_ready,
    output o_in_ready, o_d_out, o_out_sel, o_out_valid, o_beat_count
  );

  modport master (
    output i_d_in_1, i_d_in_2, i_d_in_3, i_d_in_4, i_in_valid, i_out_ready,
    input  o_in_ready, o_d_out, o_out_sel, o_out_valid, o_beat_count
  );
endinterface

// File: rtl/array_gather.sv
// Four-to-one round-robin collector: merges four lane buses into one registered
// output beat tagged with its source index, and counts delivered beats.
module array_gather #(
  parameter int ARRAY_SIZE = 9,
  parameter int DATA_SIZE  = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  array_gather_if.slave bus
);
  localparam int W = ARRAY_SIZE * DATA_SIZE;

  logic [W-1:0] r_d_out;
  logic [1:0]   r_out_sel;
  logic         r_out_valid;
  logic [1:0]   r_rr_ptr;
  logic [15:0]  r_beat_count;

  logic         w_load;
  logic         w_fire;
  logic [2:0]   w_pick;
  logic         w_found;
  logic [1:0]   w_idx;
  logic [3:0]   w_in_ready;
  logic [W-1:0] w_sel_data;

  // Lowest offset from ptr wins; the loop runs downward so that offset is written last.
  function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      res = valid[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  assign w_load  = !r_out_valid || bus.i_out_ready;
  assign w_fire  = r_out_valid && bus.i_out_ready;
  assign w_pick  = rr_pick(bus.i_in_valid, r_rr_ptr);
  assign w_found = w_pick[2];
  assign w_idx   = w_pick[1:0];

  // Accept strobe: one-hot grant, suppressed while in reset or stalled.
  always_comb begin
    w_in_ready = 4'b0000;
    if (!i_reset && w_load && w_found) begin
      w_in_ready = 4'b0001 << w_idx;
    end else begin
      w_in_ready = 4'b0000;
    end
  end

  // Source bus selection for the granted index.
  always_comb begin
    w_sel_data = '0;
    case (w_idx)
      2'd0:    w_sel_data = bus.i_d_in_1;
      2'd1:    w_sel_data = bus.i_d_in_2;
      2'd2:    w_sel_data = bus.i_d_in_3;
      2'd3:    w_sel_data = bus.i_d_in_4;
      default: w_sel_data = '0;
    endcase
  end

  // Output register, round-robin pointer and delivered-beat counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_d_out      <= '0;
      r_out_sel    <= 2'd0;
      r_out_valid  <= 1'b0;
      r_rr_ptr     <= 2'd0;
      r_beat_count <= 16'd0;
    end else begin
      if (w_load) begin
        if (w_found) begin
          r_d_out     <= w_sel_data;
          r_out_sel   <= w_idx;
          r_out_valid <= 1'b1;
          r_rr_ptr    <= w_idx + 2'd1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      if (w_fire) begin
        r_beat_count <= r_beat_count + 16'd1;
      end
    end
  end

  assign bus.o_in_ready   = w_in_ready;
  assign bus.o_d_out      = r_d_out;
  assign bus.o_out_sel    = r_out_sel;
  assign bus.o_out_valid  = r_out_valid;
  assign bus.o_beat_count = r_beat_count;
endmodule
